// File: rtl/dwpe_ctrl.sv
// dwpe_ctrl: tap/tile/channel sequencer for one depthwise PE.
// Streams KSIZE^2 weight+pixel reads, waits for the MAC result, writes it out.
module dwpe_ctrl #(
    parameter int POX   = 16,
    parameter int KSIZE = 3,
    parameter int CH_W  = 10,
    parameter int TL_W  = 10,
    parameter int AW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CH_W-1:0] num_ch,
    input  logic [TL_W-1:0] num_tiles,
    output logic            busy,
    output logic            done,
    output logic            wbuf_rd_en,
    output logic [AW-1:0]   wbuf_raddr,
    output logic            pbuf_rd_en,
    output logic [AW-1:0]   pbuf_raddr,
    output logic            dwpe_ena,
    input  logic            result_valid_0,
    output logic            obuf_wr,
    output logic [AW-1:0]   obuf_addr,
    input  logic            obuf_ready
);
    localparam int KK    = KSIZE * KSIZE;
    localparam int TAP_W = $clog2(KK + 1);
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(KK - 1);
    localparam logic [AW-1:0]    W_STEP   = AW'(KK);

    generate
        if (POX < 1 || KSIZE < 1) begin : g_bad_param
            $error("dwpe_ctrl: POX and KSIZE must be positive");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DRAIN, S_WRITE, S_NEXT, S_FIN
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CH_W-1:0]   r_nch;
    logic [TL_W-1:0]   r_ntl;
    logic [CH_W-1:0]   r_ch;
    logic [TL_W-1:0]   r_tile;
    logic [TAP_W-1:0]  r_tap;
    logic [AW-1:0]     r_wbase;
    logic [AW-1:0]     r_paddr;
    logic [AW-1:0]     r_oidx;
    logic              r_ena;
    logic              w_zero;
    logic              w_last_tile;
    logic              w_last_ch;

    assign w_zero      = (num_ch == '0) || (num_tiles == '0);
    assign w_last_tile = (r_tile == r_ntl - TL_W'(1));
    assign w_last_ch   = (r_ch == r_nch - CH_W'(1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = w_zero ? S_FIN : S_LOAD;
            S_LOAD:  if (r_tap == TAP_LAST) w_next = S_DRAIN;
            S_DRAIN: if (result_valid_0) w_next = S_WRITE;
            S_WRITE: if (obuf_ready) w_next = S_NEXT;
            S_NEXT:  w_next = (w_last_ch && w_last_tile) ? S_FIN : S_LOAD;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Running pointers: weight base steps per channel, pixel pointer never rewinds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nch   <= '0;
            r_ntl   <= '0;
            r_ch    <= '0;
            r_tile  <= '0;
            r_tap   <= '0;
            r_wbase <= '0;
            r_paddr <= '0;
            r_oidx  <= '0;
            r_ena   <= 1'b0;
        end else begin
            r_ena <= (r_state == S_LOAD);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_nch   <= num_ch;
                        r_ntl   <= num_tiles;
                        r_ch    <= '0;
                        r_tile  <= '0;
                        r_tap   <= '0;
                        r_wbase <= '0;
                        r_paddr <= '0;
                        r_oidx  <= '0;
                    end
                end
                S_LOAD: begin
                    r_paddr <= r_paddr + AW'(1);
                    r_tap   <= (r_tap == TAP_LAST) ? '0 : r_tap + TAP_W'(1);
                end
                S_NEXT: begin
                    r_oidx <= r_oidx + AW'(1);
                    if (w_last_tile) begin
                        r_tile  <= '0;
                        r_ch    <= r_ch + CH_W'(1);
                        r_wbase <= r_wbase + W_STEP;
                    end else begin
                        r_tile <= r_tile + TL_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy       = (r_state != S_IDLE);
        done       = 1'b0;
        wbuf_rd_en = 1'b0;
        pbuf_rd_en = 1'b0;
        wbuf_raddr = '0;
        pbuf_raddr = '0;
        obuf_wr    = 1'b0;
        obuf_addr  = '0;
        unique case (r_state)
            S_LOAD: begin
                wbuf_rd_en = 1'b1;
                pbuf_rd_en = 1'b1;
                wbuf_raddr = r_wbase + AW'(r_tap);
                pbuf_raddr = r_paddr;
            end
            S_WRITE: begin
                obuf_wr   = 1'b1;
                obuf_addr = r_oidx;
            end
            S_FIN:   done = 1'b1;
            default: ;
        endcase
    end

    assign dwpe_ena = r_ena;

endmodule

// File: tb/tb_dwpe_ctrl.sv
// tb_dwpe_ctrl: directed bench for dwpe_ctrl (KSIZE=3).
// Inputs change 1 ns after each rising edge; outputs are checked there too.
module tb_dwpe_ctrl;
    localparam int KK = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  num_ch = '0;
    logic [9:0]  num_tiles = '0;
    logic        busy, done;
    logic        wbuf_rd_en, pbuf_rd_en, dwpe_ena, obuf_wr;
    logic [15:0] wbuf_raddr, pbuf_raddr, obuf_addr;
    logic        result_valid_0 = 1'b0;
    logic        obuf_ready = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_wr    = 0;

    dwpe_ctrl #(
        .POX(16), .KSIZE(3), .CH_W(10), .TL_W(10), .AW(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .num_ch(num_ch),
        .num_tiles(num_tiles),
        .busy(busy),
        .done(done),
        .wbuf_rd_en(wbuf_rd_en),
        .wbuf_raddr(wbuf_raddr),
        .pbuf_rd_en(pbuf_rd_en),
        .pbuf_raddr(pbuf_raddr),
        .dwpe_ena(dwpe_ena),
        .result_valid_0(result_valid_0),
        .obuf_wr(obuf_wr),
        .obuf_addr(obuf_addr),
        .obuf_ready(obuf_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) n_done++;
        if (obuf_wr && obuf_ready) n_wr++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_wen"}, wbuf_rd_en, 0);
        chk({tag, "_pen"}, pbuf_rd_en, 0);
        chk({tag, "_ena"}, dwpe_ena, 0);
        chk({tag, "_owr"}, obuf_wr, 0);
        chk({tag, "_waddr"}, wbuf_raddr, 0);
        chk({tag, "_paddr"}, pbuf_raddr, 0);
        chk({tag, "_oaddr"}, obuf_addr, 0);
    endtask

    // Called in the first LOAD cycle of a tile; returns in the cycle after NEXT.
    task automatic run_tile(input int wb, input int pb, input int oa,
                            input int stall);
        for (int t = 0; t < KK; t++) begin
            chk("ld_wen", wbuf_rd_en, 1);
            chk("ld_pen", pbuf_rd_en, 1);
            chk("ld_waddr", wbuf_raddr, wb + t);
            chk("ld_paddr", pbuf_raddr, pb + t);
            chk("ld_ena", dwpe_ena, (t > 0) ? 1 : 0);
            chk("ld_busy", busy, 1);
            tick();
        end
        chk("dr_ena_last", dwpe_ena, 1);
        chk("dr_rd", wbuf_rd_en, 0);
        tick();
        chk("dr_ena_off", dwpe_ena, 0);
        chk("dr_owr", obuf_wr, 0);
        result_valid_0 = 1'b1;
        obuf_ready = (stall == 0);
        tick();
        result_valid_0 = 1'b0;
        for (int s = 0; s < stall; s++) begin
            chk("st_owr", obuf_wr, 1);
            chk("st_oaddr", obuf_addr, oa);
            chk("st_rd", wbuf_rd_en | pbuf_rd_en, 0);
            tick();
        end
        obuf_ready = 1'b1;
        chk("wr_owr", obuf_wr, 1);
        chk("wr_oaddr", obuf_addr, oa);
        tick();
        chk("nx_owr", obuf_wr, 0);
        chk("nx_rd", wbuf_rd_en, 0);
        chk("nx_busy", busy, 1);
        tick();
    endtask

    initial begin
        int d0, w0;
        tick();
        tick();
        chk_quiet("rst");
        rst = 1'b0;
        tick();
        chk_quiet("idle");

        // single channel, single tile
        d0 = n_done; w0 = n_wr;
        num_ch = 10'd1; num_tiles = 10'd1; start = 1'b1;
        tick();
        run_tile(0, 0, 0, 0);
        chk("t1_fin_done", done, 1);
        chk("t1_fin_busy", busy, 1);
        tick();
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_done", done, 0);
        chk("t1_ndone", n_done - d0, 1);
        chk("t1_nwr", n_wr - w0, 1);

        // 2 ch x 3 tiles, start re-pulsed with other counts during LOAD
        d0 = n_done; w0 = n_wr;
        num_ch = 10'd2; num_tiles = 10'd3; start = 1'b1;
        tick();
        num_ch = 10'd5; num_tiles = 10'd7; start = 1'b1;
        for (int c = 0; c < 2; c++)
            for (int t = 0; t < 3; t++)
                run_tile(9 * c, 9 * (3 * c + t), 3 * c + t, 0);
        chk("t2_fin_done", done, 1);
        tick();
        chk("t2_idle_busy", busy, 0);
        chk("t2_ndone", n_done - d0, 1);
        chk("t2_nwr", n_wr - w0, 6);

        // backpressure: 4 cycles of obuf_ready low on the first tile
        d0 = n_done; w0 = n_wr;
        num_ch = 10'd1; num_tiles = 10'd2; start = 1'b1;
        tick();
        run_tile(0, 0, 0, 4);
        run_tile(0, 9, 1, 0);
        chk("t3_fin_done", done, 1);
        tick();
        chk("t3_ndone", n_done - d0, 1);
        chk("t3_nwr", n_wr - w0, 2);

        // zero work
        d0 = n_done; w0 = n_wr;
        num_ch = 10'd3; num_tiles = 10'd0; start = 1'b1;
        tick();
        chk("t4_busy", busy, 1);
        chk("t4_done", done, 1);
        chk("t4_rd", wbuf_rd_en | pbuf_rd_en, 0);
        chk("t4_ena", dwpe_ena, 0);
        tick();
        chk_quiet("t4_after");
        tick();
        chk("t4_ndone", n_done - d0, 1);
        chk("t4_nwr", n_wr - w0, 0);

        // reset during LOAD tap 4, then a fresh layer
        num_ch = 10'd1; num_tiles = 10'd1; start = 1'b1;
        tick();
        for (int t = 0; t < 4; t++) tick();
        chk("t5_tap4_waddr", wbuf_raddr, 4);
        chk("t5_tap4_paddr", pbuf_raddr, 4);
        rst = 1'b1;
        tick();
        chk_quiet("t5_rst");
        rst = 1'b0;
        tick();
        chk_quiet("t5_idle");
        d0 = n_done;
        start = 1'b1;
        tick();
        run_tile(0, 0, 0, 0);
        chk("t5_fin_done", done, 1);
        tick();
        chk("t5_idle_busy", busy, 0);
        chk("t5_ndone", n_done - d0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
